// File: rtl/adder_accumulator.sv
// Multi-lane streaming frame accumulator with valid/ready on both sides.
// Sums LANES operands per beat; a frame result is presented after last_i.
module adder_accumulator #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 2,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8,
    parameter int SATURATE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] data_i,
    input  logic                   last_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [ACC_WIDTH-1:0]   sum_o,
    output logic [CNT_WIDTH-1:0]   beats_o,
    output logic                   overflow_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int EXT = ACC_WIDTH + LW + 1;
    localparam logic [EXT-1:0] MAX_EXT =
        {{(EXT-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 ovf;
    logic                 ovf_nxt;
    logic [EXT-1:0]       beat_sum;
    logic [EXT-1:0]       sum_ext;

    assign ready_o = (state == ACCUM) && !rst;

    // Next accumulator, counter and sticky overflow for the current beat
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum +
                {{(EXT-WIDTH){1'b0}}, data_i[k*WIDTH +: WIDTH]};
        end
        sum_ext = {{(EXT-ACC_WIDTH){1'b0}}, acc} + beat_sum;
        ovf_nxt = ovf || (sum_ext > MAX_EXT);
        if ((SATURATE != 0) && ovf_nxt) begin
            acc_nxt = '1;
        end else begin
            acc_nxt = sum_ext[ACC_WIDTH-1:0];
        end
        cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
    end

    // Frame state machine: accumulate beats, then hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            sum_o      <= '0;
            beats_o    <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (valid_i && ready_o) begin
                        if (last_i) begin
                            sum_o      <= acc_nxt;
                            beats_o    <= cnt_nxt;
                            overflow_o <= ovf_nxt;
                            valid_o    <= 1'b1;
                            state      <= HOLD;
                            acc        <= '0;
                            cnt        <= '0;
                            ovf        <= 1'b0;
                        end else begin
                            acc <= acc_nxt;
                            cnt <= cnt_nxt;
                            ovf <= ovf_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (valid_o && ready_i) begin
                        valid_o <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed bench for adder_accumulator: default, 9-bit wrap and
// 9-bit saturate instances share one stimulus stream.
module tb_adder_accumulator;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic        last;
    logic        valid;
    logic        ready_i;

    logic        ro_d, ro_w, ro_s;
    logic [15:0] sum_d;
    logic [8:0]  sum_w, sum_s;
    logic [7:0]  bt_d, bt_w, bt_s;
    logic        ov_d, ov_w, ov_s;
    logic        vo_d, vo_w, vo_s;

    int n_chk  = 0;
    int n_pass = 0;

    adder_accumulator u_def (
        .clk(clk), .rst(rst), .data_i(data), .last_i(last),
        .valid_i(valid), .ready_o(ro_d), .sum_o(sum_d),
        .beats_o(bt_d), .overflow_o(ov_d), .valid_o(vo_d),
        .ready_i(ready_i)
    );

    adder_accumulator #(.ACC_WIDTH(9), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .data_i(data), .last_i(last),
        .valid_i(valid), .ready_o(ro_w), .sum_o(sum_w),
        .beats_o(bt_w), .overflow_o(ov_w), .valid_o(vo_w),
        .ready_i(ready_i)
    );

    adder_accumulator #(.ACC_WIDTH(9), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .data_i(data), .last_i(last),
        .valid_i(valid), .ready_o(ro_s), .sum_o(sum_s),
        .beats_o(bt_s), .overflow_o(ov_s), .valid_o(vo_s),
        .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Present one beat at a negedge; returns at the following negedge
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic l);
        data  = {b, a};
        valid = 1'b1;
        last  = l;
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        data    = '0;
        last    = 1'b0;
        valid   = 1'b0;
        ready_i = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_valid", 32'(vo_d), 0);
        check("rst_ready", 32'(ro_d), 0);
        check("rst_sum", 32'(sum_d), 0);
        check("rst_beats", 32'(bt_d), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(ro_d), 1);

        // single beat frame
        send(8'd4, 8'd6, 1'b1);
        check("t1_valid", 32'(vo_d), 1);
        check("t1_sum", 32'(sum_d), 10);
        check("t1_beats", 32'(bt_d), 1);
        check("t1_ovf", 32'(ov_d), 0);
        check("t1_ready_hold", 32'(ro_d), 0);
        @(negedge clk);
        check("t1_valid_drop", 32'(vo_d), 0);
        check("t1_ready_back", 32'(ro_d), 1);

        // two beat frame
        send(8'd127, 8'd127, 1'b0);
        check("t2_no_valid", 32'(vo_d), 0);
        send(8'd128, 8'd128, 1'b1);
        check("t2_sum", 32'(sum_d), 510);
        check("t2_beats", 32'(bt_d), 2);
        check("t2_ovf", 32'(ov_d), 0);
        check("t2_sum_w9", 32'(sum_w), 510);
        @(negedge clk);

        // 9-bit boundary: exactly 511, no overflow
        send(8'd255, 8'd255, 1'b0);
        send(8'd1, 8'd0, 1'b1);
        check("t3a_sum_w", 32'(sum_w), 511);
        check("t3a_ovf_w", 32'(ov_w), 0);
        check("t3a_ovf_s", 32'(ov_s), 0);
        @(negedge clk);

        // 9-bit overflow by one
        send(8'd255, 8'd255, 1'b0);
        send(8'd1, 8'd1, 1'b1);
        check("t3b_sum_w", 32'(sum_w), 0);
        check("t3b_ovf_w", 32'(ov_w), 1);
        check("t3b_sum_s", 32'(sum_s), 511);
        check("t3b_sum_d", 32'(sum_d), 512);
        check("t3b_ovf_d", 32'(ov_d), 0);
        @(negedge clk);

        // saturation persists through later beats
        send(8'd255, 8'd255, 1'b0);
        send(8'd1, 8'd1, 1'b0);
        send(8'd3, 8'd0, 1'b1);
        check("t4_sum_s", 32'(sum_s), 511);
        check("t4_ovf_s", 32'(ov_s), 1);
        check("t4_beats_s", 32'(bt_s), 3);
        check("t4_sum_w", 32'(sum_w), 3);
        check("t4_ovf_w", 32'(ov_w), 1);
        @(negedge clk);

        // backpressure on the result port
        ready_i = 1'b0;
        send(8'd20, 8'd30, 1'b1);
        for (int i = 0; i < 5; i++) begin
            data  = {8'd99, 8'd99};
            valid = 1'b1;
            last  = 1'b1;
            @(negedge clk);
            check("t5_ready_low", 32'(ro_d), 0);
            check("t5_valid_held", 32'(vo_d), 1);
            check("t5_sum_held", 32'(sum_d), 50);
            check("t5_beats_held", 32'(bt_d), 1);
        end
        valid   = 1'b0;
        last    = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("t5_valid_drop", 32'(vo_d), 0);
        check("t5_ready_back", 32'(ro_d), 1);
        send(8'd5, 8'd6, 1'b1);
        check("t5_next_sum", 32'(sum_d), 11);
        check("t5_next_beats", 32'(bt_d), 1);
        @(negedge clk);

        // beat counter saturates at 255
        repeat (299) send(8'd1, 8'd0, 1'b0);
        send(8'd1, 8'd0, 1'b1);
        check("cnt_sat_beats", 32'(bt_d), 255);
        check("cnt_sat_sum", 32'(sum_d), 300);
        @(negedge clk);

        // reset while holding a result
        ready_i = 1'b0;
        send(8'd2, 8'd2, 1'b1);
        check("hold_valid", 32'(vo_d), 1);
        rst = 1'b1;
        @(negedge clk);
        check("hold_rst_valid", 32'(vo_d), 0);
        check("hold_rst_ready", 32'(ro_d), 0);
        rst     = 1'b0;
        ready_i = 1'b1;

        // reset mid-frame discards partial sum
        send(8'd10, 8'd10, 1'b0);
        send(8'd10, 8'd10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 32'(vo_d), 0);
        check("t6_rst_ready", 32'(ro_d), 0);
        rst = 1'b0;
        send(8'd1, 8'd2, 1'b1);
        check("t6_sum", 32'(sum_d), 3);
        check("t6_beats", 32'(bt_d), 1);
        check("t6_valid", 32'(vo_d), 1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_accumulator.md
# adder_accumulator

Parametrised multi-lane streaming accumulator.
- Each accepted input beat adds LANES unsigned WIDTH-bit operands into an ACC_WIDTH-bit accumulator.
- A frame ends on the beat marked `last_i`; the frame sum, beat count and overflow flag are then presented on a valid/ready output port.
- Successor to the single-operand adder-plus-valid-register pair: adds backpressure on both sides, lanes, framing, and wrap or saturate overflow handling.

## Interface
- WIDTH, 8, bit width of each lane operand
- LANES, 2, operands summed per beat (>=1)
- ACC_WIDTH, 16, accumulator and result width (>= WIDTH)
- CNT_WIDTH, 8, beat counter width
- SATURATE, 0, overflow mode: 0 = wrap modulo 2^ACC_WIDTH, 1 = clamp to 2^ACC_WIDTH-1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- data_i  in  LANES*WIDTH  operands; lane k at [k*WIDTH +: WIDTH], unsigned
- last_i  in  1  marks final beat of frame (qualified by valid_i)
- valid_i  in  1  input beat valid
- ready_o  out  1  accumulator accepts a beat
- sum_o  out  ACC_WIDTH  frame sum
- beats_o  out  CNT_WIDTH  accepted beats in frame, including last
- overflow_o  out  1  frame sum exceeded 2^ACC_WIDTH-1 at any beat
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result

## Operation
- States: ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - ready_o = 1.
  - A beat is accepted when valid_i && ready_o.
  - Computation is done in ACC_WIDTH+clog2(LANES)+1 bits, all operands zero-extended: beat_sum = sum of all lanes; nxt = acc + beat_sum.
  - If nxt > 2^ACC_WIDTH-1, the frame overflow flag is set (sticky until the frame is handed off).
  - SATURATE=0: acc <= nxt[ACC_WIDTH-1:0].
  - SATURATE=1: acc <= 2^ACC_WIDTH-1, and it stays clamped for the rest of the frame.
  - The beat counter increments per accepted beat and saturates at 2^CNT_WIDTH-1.
- Accepted beat with last_i = 1:
  - The final acc, count and overflow values, including this beat, are registered into sum_o, beats_o and overflow_o.
  - valid_o <= 1; state <= HOLD.
  - Internal acc, counter and flag are cleared.
- HOLD:
  - ready_o = 0; valid_i and data_i are ignored.
  - sum_o, beats_o and overflow_o are held stable.
  - On valid_o && ready_i: valid_o <= 0 and state <= ACCUM.
- Output registers keep their last values after handoff; they are only meaningful while valid_o = 1.
- Zero-beat frames do not exist; a frame always contains at least its last beat.

## Timing
- Reset values, applied while rst = 1: valid_o = 0, sum_o = 0, beats_o = 0, overflow_o = 0, acc/counter/flag = 0, state ACCUM.
- ready_o is forced to 0 while rst = 1 and is 1 in the first cycle after rst falls.
- Latency: valid_o rises on the edge that accepts the last beat, i.e. it is visible in the next cycle.
- Throughput:
  - One beat per cycle inside a frame.
  - Each frame adds one HOLD cycle minimum, so N beats occupy N+1 cycles when ready_i = 1.
  - ready_o returns to 1 in the cycle after the output handshake.
- ready_o depends only on state and rst; there is no combinational path from ready_i or valid_i.
- valid_o, once raised, stays high with stable data until ready_i is sampled high.
- Reset mid-frame discards the partial accumulation. Reset in HOLD drops valid_o at that edge without a handshake.
- Boundary at exactly 2^ACC_WIDTH-1: overflow_o = 0. Overflow only when that value is exceeded.

## Test plan
1. Default params, single beat lanes (4,6), last = 1 → sum_o = 10, beats_o = 1, overflow_o = 0, valid_o one cycle after acceptance.
2. Frame of two beats (127,127), (128,128 last) → sum_o = 510, beats_o = 2, overflow_o = 0.
3. ACC_WIDTH=9, SATURATE=0:
   - beats (255,255), (1,0 last) → sum_o = 511, overflow_o = 0.
   - beats (255,255), (1,1 last) → sum_o = 0, overflow_o = 1.
4. ACC_WIDTH=9, SATURATE=1, beats (255,255), (1,1), (3,0 last) → sum_o = 511, overflow_o = 1, beats_o = 3.
5. Backpressure: hold ready_i = 0 for 5 cycles after valid_o with valid_i = 1 and new data → ready_o = 0, outputs stable. On ready_i = 1, handshake; the next frame starts accumulating from 0.
6. rst pulse after 2 beats of (10,10) → valid_o = 0, ready_o = 0 during rst. The next frame (1,2 last) yields sum_o = 3, beats_o = 1.
